// File: rtl/sqseq_pkg.sv
// sqseq_pkg: shared definitions for the square sequencer.
//   - sqseq_state_e : FSM state encoding (IDLE/CLEAR/SQUARE/DONE)
//   - SQSEQ_COORD_W, SQSEQ_DEPTH_W : default coordinate and depth widths
//   - sqseq_idx_w() : width of a slot index for a given slot count (min 1)
package sqseq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SQUARE = 3'd2,
    DONE   = 3'd3
  } sqseq_state_e;

  localparam int SQSEQ_COORD_W = 9;
  localparam int SQSEQ_DEPTH_W = 6;

  function automatic int sqseq_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sqseq_pick.sv
// sqseq_pick: combinational choice of the next slot to present.
// Optional build macro: SQSEQ_DEPTH_SORT_EN
//   defined   -> deepest pending slot first, ties to the lowest index
//   undefined -> lowest-index pending slot
// Ports:
//   pending  in  NUM_SQUARES          slots still to be drawn this frame
//   d_snap   in  NUM_SQUARES*DEPTH_W  frame-start depth snapshot
//   cur      out IDX_W                selected slot (0 when none pending)
//   none     out 1                    no slot pending
module sqseq_pick
  import sqseq_pkg::*;
#(
  parameter int NUM_SQUARES = 4,
  parameter int DEPTH_W     = SQSEQ_DEPTH_W,
  parameter int IDX_W       = sqseq_idx_w(NUM_SQUARES)
) (
  input  logic [NUM_SQUARES-1:0]         pending,
  input  logic [NUM_SQUARES*DEPTH_W-1:0] d_snap,
  output logic [IDX_W-1:0]               cur,
  output logic                           none
);

`ifdef SQSEQ_DEPTH_SORT_EN
  logic [DEPTH_W-1:0] best;
  logic               found;

  // Strict '>' keeps the earlier (lower) index on equal depths.
  always_comb begin
    cur   = '0;
    best  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SQUARES; i++) begin
      if (pending[i] && (!found || (d_snap[i*DEPTH_W +: DEPTH_W] > best))) begin
        cur   = IDX_W'(i);
        best  = d_snap[i*DEPTH_W +: DEPTH_W];
        found = 1'b1;
      end
    end
  end
`else
  // Depths only matter for the sorted pick.
  logic unused_d_snap;
  assign unused_d_snap = ^d_snap;

  // Scan downwards so the lowest set index is the last to win.
  always_comb begin
    cur = '0;
    for (int i = NUM_SQUARES - 1; i >= 0; i--) begin
      if (pending[i]) cur = IDX_W'(i);
    end
  end
`endif

  assign none = ~|pending;

endmodule

// File: rtl/square_sequencer.sv
// square_sequencer: per frame, one optional clear pass, then up to
// NUM_SQUARES square centres/depths handed one at a time to the edge engine.
// Optional build macro: SQSEQ_DEPTH_SORT_EN (selection order, see sqseq_pick).
// Ports:
//   clock, reset_n          clock, async active-low reset
//   enable                  advance qualifier; low freezes all state
//   topready                frame request (accepted in IDLE only)
//   doneclear, donesquare   engine completion handshakes
//   clear_en                run the clear pass (sampled with topready)
//   sq_valid, xc/yc/d_bus   per-slot request mask and packed slot data
//   clear, busy, frame_done status (combinational from state)
//   enedge, xcenter, ycenter, depth, sq_index  registered current square
//
// state  | meaning
// IDLE   | waiting for topready; snapshot taken on acceptance
// CLEAR  | clear engine running, waiting for doneclear
// SQUARE | presenting pending slots, one per donesquare
// DONE   | single cycle, frame_done pulse
module square_sequencer
  import sqseq_pkg::*;
#(
  parameter int  NUM_SQUARES = 4,
  parameter int  COORD_W     = SQSEQ_COORD_W,
  parameter int  DEPTH_W     = SQSEQ_DEPTH_W,
  localparam int IDX_W       = sqseq_idx_w(NUM_SQUARES)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           topready,
  input  logic                           doneclear,
  input  logic                           donesquare,
  input  logic                           clear_en,
  input  logic [NUM_SQUARES-1:0]         sq_valid,
  input  logic [NUM_SQUARES*COORD_W-1:0] xc_bus,
  input  logic [NUM_SQUARES*COORD_W-1:0] yc_bus,
  input  logic [NUM_SQUARES*DEPTH_W-1:0] d_bus,
  output logic                           clear,
  output logic                           enedge,
  output logic [COORD_W-1:0]             xcenter,
  output logic [COORD_W-1:0]             ycenter,
  output logic [DEPTH_W-1:0]             depth,
  output logic [IDX_W-1:0]               sq_index,
  output logic                           busy,
  output logic                           frame_done
);

  sqseq_state_e                   state, state_nxt;
  logic [NUM_SQUARES-1:0]         pending, cur_mask, pending_rest;
  logic [NUM_SQUARES*COORD_W-1:0] xc_snap, yc_snap;
  logic [NUM_SQUARES*DEPTH_W-1:0] d_snap;
  logic [IDX_W-1:0]               cur;
  logic                           none;
  logic                           accept, square_done, presenting;

  sqseq_pick #(
    .NUM_SQUARES (NUM_SQUARES),
    .DEPTH_W     (DEPTH_W),
    .IDX_W       (IDX_W)
  ) u_pick (
    .pending (pending),
    .d_snap  (d_snap),
    .cur     (cur),
    .none    (none)
  );

  assign cur_mask     = NUM_SQUARES'(1) << cur;
  assign pending_rest = pending & ~cur_mask;
  assign accept       = (state == IDLE) && topready;
  assign presenting   = (state == SQUARE) && !none;
  assign square_done  = presenting && donesquare;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    state <= IDLE;
    else if (enable) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (topready) state_nxt = clear_en ? CLEAR : SQUARE;
      CLEAR:   if (doneclear) state_nxt = SQUARE;
      SQUARE:  if (none || (donesquare && (pending_rest == '0))) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // frame_done is qualified by enable so it marks the cycle DONE is actually left.
  always_comb begin
    clear      = (state == CLEAR);
    busy       = (state != IDLE);
    frame_done = (state == DONE) && enable;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      xc_snap <= '0;
      yc_snap <= '0;
      d_snap  <= '0;
    end else if (enable) begin
      if (accept) begin
        pending <= sq_valid;
        xc_snap <= xc_bus;
        yc_snap <= yc_bus;
        d_snap  <= d_bus;
      end else if (square_done) begin
        pending <= pending_rest;
      end
    end
  end

  // Presented square trails the state/cur change by one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enedge   <= 1'b0;
      xcenter  <= '0;
      ycenter  <= '0;
      depth    <= '0;
      sq_index <= '0;
    end else if (enable) begin
      if (presenting) begin
        enedge   <= 1'b1;
        xcenter  <= xc_snap[int'(cur)*COORD_W +: COORD_W];
        ycenter  <= yc_snap[int'(cur)*COORD_W +: COORD_W];
        depth    <= d_snap[int'(cur)*DEPTH_W +: DEPTH_W];
        sq_index <= cur;
      end else begin
        enedge   <= 1'b0;
        xcenter  <= '0;
        ycenter  <= '0;
        depth    <= '0;
        sq_index <= '0;
      end
    end
  end

endmodule

// File: tb/tb_square_sequencer.sv
module tb_square_sequencer;
  localparam int N  = 4;
  localparam int CW = 9;
  localparam int DW = 6;
  localparam int IW = 2;
`ifdef SQSEQ_DEPTH_SORT_EN
  localparam bit SORT = 1'b1;
`else
  localparam bit SORT = 1'b0;
`endif

  logic clock = 1'b0, reset_n = 1'b0, enable = 1'b0, topready = 1'b0;
  logic doneclear = 1'b0, donesquare = 1'b0, clear_en = 1'b0;
  logic [N-1:0]    sq_valid = '0;
  logic [N*CW-1:0] xc_bus = '0, yc_bus = '0;
  logic [N*DW-1:0] d_bus = '0;
  logic            clear, enedge, busy, frame_done;
  logic [CW-1:0]   xcenter, ycenter;
  logic [DW-1:0]   depth;
  logic [IW-1:0]   sq_index;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  square_sequencer #(.NUM_SQUARES(N), .COORD_W(CW), .DEPTH_W(DW)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .topready(topready),
    .doneclear(doneclear), .donesquare(donesquare), .clear_en(clear_en),
    .sq_valid(sq_valid), .xc_bus(xc_bus), .yc_bus(yc_bus), .d_bus(d_bus),
    .clear(clear), .enedge(enedge), .xcenter(xcenter), .ycenter(ycenter),
    .depth(depth), .sq_index(sq_index), .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    string           tag;
    logic [N-1:0]    v;
    logic            ce;
    logic [N*CW-1:0] xs;
    logic [N*CW-1:0] ys;
    logic [N*DW-1:0] ds;
    int              cnt;
    logic [7:0]      ord_lin;  // position k at [2k+:2]
    logic [7:0]      ord_srt;
    bit              mutate;
  } vec_t;

  vec_t tbl[7];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int depth_of(input logic [N*DW-1:0] d, input int s);
    return int'(d[s*DW +: DW]);
  endfunction

  // Expected presentation order: valid slots ascending, optionally
  // stable-sorted deepest first.
  function automatic int model_order(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                                     input bit srt, output int ord[N]);
    int cnt = 0;
    for (int i = 0; i < N; i++) ord[i] = 0;
    for (int i = 0; i < N; i++) if (v[i]) begin ord[cnt] = i; cnt++; end
    if (srt) begin
      for (int a = 1; a < cnt; a++) begin
        int key = ord[a];
        int b = a - 1;
        while (b >= 0 && depth_of(d, ord[b]) < depth_of(d, key)) begin
          ord[b+1] = ord[b];
          b--;
        end
        ord[b+1] = key;
      end
    end
    return cnt;
  endfunction

  function automatic logic [N*CW-1:0] rand_coords();
    logic [N*CW-1:0] r;
    for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'($urandom);
    return r;
  endfunction

  function automatic logic [N*DW-1:0] rand_depths();
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_enedge"}, enedge, 0);
    chk({tag, "_xcenter"}, xcenter, 0);
    chk({tag, "_ycenter"}, ycenter, 0);
    chk({tag, "_depth"}, depth, 0);
    chk({tag, "_sq_index"}, sq_index, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_clear"}, clear, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  // One complete frame from IDLE back to IDLE with the expected order given.
  task automatic run_frame(input string tag, input logic [N-1:0] v, input logic ce,
                           input logic [N*CW-1:0] xs, input logic [N*CW-1:0] ys,
                           input logic [N*DW-1:0] ds, input int cnt, input int ord[N],
                           input bit mutate);
    int slot, w;
    topready = 1'b1; clear_en = ce; sq_valid = v;
    xc_bus = xs; yc_bus = ys; d_bus = ds;
    step();
    topready = 1'b0;
    clear_en = 1'($urandom_range(0, 1));
    if (mutate) begin
      xc_bus = rand_coords();
      xc_bus[CW-1:0] = 9'd200;
      yc_bus = rand_coords();
      d_bus  = rand_depths();
      sq_valid = ~v;
    end
    chk({tag, "_busy_accept"}, busy, 1);
    chk({tag, "_clear_accept"}, clear, ce);
    if (ce) begin
      w = $urandom_range(0, 2);
      repeat (w) begin
        donesquare = 1'($urandom_range(0, 1));
        topready   = 1'($urandom_range(0, 1));
        step();
        donesquare = 1'b0; topready = 1'b0;
        chk({tag, "_clear_hold"}, clear, 1);
      end
      doneclear = 1'b1;
      donesquare = 1'($urandom_range(0, 1));
      step();
      doneclear = 1'b0; donesquare = 1'b0;
      chk({tag, "_clear_off"}, clear, 0);
    end
    chk({tag, "_enedge_entry"}, enedge, 0);
    for (int k = 0; k < cnt; k++) begin
      slot = ord[k];
      step();
      chk({tag, "_enedge"}, enedge, 1);
      chk({tag, "_sq_index"}, sq_index, slot);
      chk({tag, "_xcenter"}, xcenter, xs[slot*CW +: CW]);
      chk({tag, "_ycenter"}, ycenter, ys[slot*CW +: CW]);
      chk({tag, "_depth"}, depth, ds[slot*DW +: DW]);
      w = $urandom_range(0, 2);
      repeat (w) begin
        doneclear = 1'($urandom_range(0, 1));
        topready  = 1'($urandom_range(0, 1));
        step();
        doneclear = 1'b0; topready = 1'b0;
        chk({tag, "_sq_index_hold"}, sq_index, slot);
      end
      donesquare = 1'b1;
      step();
      donesquare = 1'b0;
    end
    if (cnt == 0) step();
    chk({tag, "_frame_done"}, frame_done, 1);
    chk({tag, "_busy_done"}, busy, 1);
    step();
    check_idle_outputs({tag, "_end"});
  endtask

  task automatic run_vec(input vec_t t);
    int ord[N];
    logic [7:0] packed_ord;
    packed_ord = SORT ? t.ord_srt : t.ord_lin;
    for (int k = 0; k < N; k++) ord[k] = int'(packed_ord[2*k +: 2]);
    run_frame(t.tag, t.v, t.ce, t.xs, t.ys, t.ds, t.cnt, ord, t.mutate);
  endtask

  initial begin
    tbl[0] = '{"basic", 4'b1111, 1'b1, {9'd40, 9'd30, 9'd20, 9'd10},
               {9'd41, 9'd31, 9'd21, 9'd11}, {6'd5, 6'd40, 6'd40, 6'd10},
               4, {2'd3, 2'd2, 2'd1, 2'd0}, {2'd3, 2'd0, 2'd2, 2'd1}, 1'b0};
    tbl[1] = '{"sparse", 4'b1010, 1'b0, {9'd333, 9'd7, 9'd111, 9'd9},
               {9'd334, 9'd8, 9'd112, 9'd6}, {6'd8, 6'd50, 6'd3, 6'd60},
               2, {2'd0, 2'd0, 2'd3, 2'd1}, {2'd0, 2'd0, 2'd1, 2'd3}, 1'b0};
    tbl[2] = '{"empty_clr", 4'b0000, 1'b1, {9'd1, 9'd2, 9'd3, 9'd4},
               {9'd5, 9'd6, 9'd7, 9'd8}, {6'd1, 6'd2, 6'd3, 6'd4},
               0, 8'h00, 8'h00, 1'b0};
    tbl[3] = '{"empty_noclr", 4'b0000, 1'b0, {9'd1, 9'd2, 9'd3, 9'd4},
               {9'd5, 9'd6, 9'd7, 9'd8}, {6'd1, 6'd2, 6'd3, 6'd4},
               0, 8'h00, 8'h00, 1'b0};
    tbl[4] = '{"single_max", 4'b1000, 1'b1, {9'd511, 9'd0, 9'd0, 9'd0},
               {9'd511, 9'd0, 9'd0, 9'd0}, {6'd63, 6'd0, 6'd0, 6'd0},
               1, 8'h03, 8'h03, 1'b0};
    tbl[5] = '{"isolation", 4'b0001, 1'b1, {9'd0, 9'd0, 9'd0, 9'd100},
               {9'd0, 9'd0, 9'd0, 9'd77}, {6'd0, 6'd0, 6'd0, 6'd12},
               1, 8'h00, 8'h00, 1'b1};
    tbl[6] = '{"ties", 4'b1111, 1'b0, {9'd4, 9'd3, 9'd2, 9'd1},
               {9'd8, 9'd7, 9'd6, 9'd5}, {6'd20, 6'd20, 6'd20, 6'd20},
               4, 8'hE4, 8'hE4, 1'b0};

    repeat (2) @(posedge clock);
    #3;
    check_idle_outputs("reset");
    reset_n = 1'b1;
    enable  = 1'b1;
    step();
    check_idle_outputs("post_reset");

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // enable low freezes SQUARE even while donesquare is asserted
    begin
      topready = 1'b1; clear_en = 1'b0; sq_valid = 4'b0011;
      xc_bus = {9'd0, 9'd0, 9'd6, 9'd5}; yc_bus = '0; d_bus = '0;
      step();
      topready = 1'b0;
      step();
      chk("en_first_idx", sq_index, 0);
      chk("en_first_x", xcenter, 5);
      enable = 1'b0; donesquare = 1'b1; topready = 1'b1;
      repeat (3) begin
        step();
        chk("en_hold_idx", sq_index, 0);
        chk("en_hold_enedge", enedge, 1);
      end
      enable = 1'b1; donesquare = 1'b0; topready = 1'b0;
      step();
      chk("en_represent_idx", sq_index, 0);
      chk("en_represent_x", xcenter, 5);
      donesquare = 1'b1;
      step();
      donesquare = 1'b0;
      step();
      chk("en_second_idx", sq_index, 1);
      chk("en_second_x", xcenter, 6);
      donesquare = 1'b1;
      step();
      donesquare = 1'b0;
      chk("en_frame_done", frame_done, 1);
      step();
      chk("en_busy_end", busy, 0);
    end

    // asynchronous reset in the middle of SQUARE
    begin
      topready = 1'b1; clear_en = 1'b0; sq_valid = 4'b1111;
      xc_bus = {9'd44, 9'd33, 9'd22, 9'd11}; yc_bus = xc_bus; d_bus = {6'd4, 6'd3, 6'd2, 6'd1};
      step();
      topready = 1'b0;
      step();
      chk("rst_pre_enedge", enedge, 1);
      #2 reset_n = 1'b0;
      #1;
      check_idle_outputs("rst_async");
      step();
      step();
      chk("rst_no_frame_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      reset_n = 1'b1;
      step();
      run_vec(tbl[0]);
    end

    // randomized frames against the order model
    for (int r = 0; r < 25; r++) begin
      logic [N-1:0]    v;
      logic [N*CW-1:0] xs, ys;
      logic [N*DW-1:0] ds;
      int              ord[N];
      int              cnt;
      v  = N'($urandom);
      xs = rand_coords();
      ys = rand_coords();
      ds = rand_depths();
      if ($urandom_range(0, 3) == 0) ds[DW-1:0] = ds[2*DW-1:DW];
      cnt = model_order(v, ds, SORT, ord);
      run_frame("rand", v, 1'($urandom_range(0, 1)), xs, ys, ds, cnt, ord,
                1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/square_sequencer.md
Name: square_sequencer

Overview:
- Parametrised successor to the four-square writer in the renderer front end.
- Each frame it runs one clear pass, then emits up to NUM_SQUARES square centres/depths, one at a time, to the edge-drawing engine, handshaking on doneclear/donesquare.
- New relative to the previous generation: per-square valid mask, coordinate snapshot at frame start, clear bypass, frame_done/busy status and sq_index.

Parameters:
- NUM_SQUARES, 4, number of square slots; legal range 1..32.
- COORD_W, 9, width of x/y centre coordinates.
- DEPTH_W, 6, width of depth value.
- IDX_W, max(1,$clog2(NUM_SQUARES)), width of sq_index (derived; not overridden).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  state-advance qualifier; when low, state, pending mask and snapshot hold.
- topready  in  1  frame request from top-level controller.
- doneclear  in  1  clear engine finished.
- donesquare  in  1  edge engine finished current square.
- clear_en  in  1  1 = run the CLEAR phase; 0 = skip it. Sampled with topready.
- sq_valid  in  NUM_SQUARES  per-slot draw request; bit i selects slot i.
- xc_bus  in  NUM_SQUARES*COORD_W  packed x centres; slot i at [i*COORD_W +: COORD_W].
- yc_bus  in  NUM_SQUARES*COORD_W  packed y centres, same packing.
- d_bus  in  NUM_SQUARES*DEPTH_W  packed depths, same packing.
- clear  out  1  high while in CLEAR (combinational from state).
- enedge  out  1  registered; high while a square is being presented.
- xcenter  out  COORD_W  registered x of current square.
- ycenter  out  COORD_W  registered y of current square.
- depth  out  DEPTH_W  registered depth of current square.
- sq_index  out  IDX_W  registered slot number of current square.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse on leaving DONE.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state = IDLE; pending mask = 0; snapshot registers = 0.
  - All registered outputs = 0; clear, busy and frame_done = 0.
  - Reset mid-frame abandons the frame with no frame_done.
- Every transition below requires enable = 1; with enable = 0 nothing changes.
- States:
  - IDLE: on topready, snapshot sq_valid into the pending mask and snapshot xc_bus, yc_bus and d_bus. Then go to CLEAR if clear_en = 1, else to SQUARE.
  - CLEAR: stay until doneclear, then go to SQUARE.
  - SQUARE:
    - If pending = 0, go to DONE.
    - Otherwise cur = the selected pending slot (lowest index by default).
    - On donesquare, clear pending[cur]. If no other bit remains set, go to DONE; else stay in SQUARE with the next cur.
  - DONE: one cycle, assert frame_done, then go to IDLE.
- All-zero sq_valid: the frame still runs CLEAR (if enabled), then DONE, then the frame_done pulse.
- Ignored inputs:
  - donesquare outside SQUARE, and doneclear outside CLEAR, are ignored.
  - topready outside IDLE is ignored; there is no queueing.
- Output timing:
  - xcenter, ycenter, depth, sq_index and enedge register the snapshot values of cur one cycle after the state/cur change (one-cycle latency).
  - When not in SQUARE (or pending = 0), these outputs load 0.
- Snapshot isolation: changes on xc_bus, yc_bus, d_bus or sq_valid during a frame have no effect until the next IDLE acceptance.
- Simultaneous doneclear and donesquare in CLEAR: only doneclear acts.
- There is no arithmetic; all widths pass through unchanged.

Optional Feature:
- Macro: SQSEQ_DEPTH_SORT_EN.
- Defined: cur = the pending slot with the largest depth (painter's order, far to near); ties go to the lowest index.
- Undefined: cur = the lowest-index pending slot.
- Handshake and timing are identical either way.

Decomposition:
- Package sqseq_pkg holds:
  - state encoding constants IDLE = 3'd0, CLEAR = 3'd1, SQUARE = 3'd2, DONE = 3'd3;
  - the default COORD_W and DEPTH_W.
- One sub-module, sqseq_pick: combinational selector.
  - Inputs: pending mask and snapshot depths.
  - Outputs: cur index and a none-pending flag.
  - Contains the SQSEQ_DEPTH_SORT_EN variant.

Test Plan:
- Basic frame, N=4, all valid, clear_en=1:
  - topready, doneclear, then 4 donesquare.
  - clear is high until doneclear.
  - sq_index goes 0,1,2,3 with matching coordinates, one cycle after each state change.
  - One frame_done pulse, then busy=0.
- Sparse mask sq_valid=4'b1010, clear_en=0: no clear; only slots 1 then 3 presented; enedge drops after the second donesquare.
- Snapshot isolation: change xc_bus[slot 0] from 9'd100 to 9'd200 after acceptance -> xcenter stays 100 for the whole frame.
- Reset mid-SQUARE: assert reset_n=0 asynchronously -> all outputs 0 immediately; no frame_done; the next topready starts a fresh frame.
- enable=0 held during SQUARE while donesquare pulses -> no advance; the same square is re-presented when enable returns.
- Depth sort, macro defined: depths {10,40,40,5} all valid -> order is 1,2,0,3; with the macro undefined -> order is 0,1,2,3.
